muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit, parametrised in width and radix.

---
 rtl/muldiv_unit_if.sv | 14 +
 rtl/muldiv_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle for the multiply/divide unit
// Ports: in_valid/in_ready/op/a/b request side; out_valid/out_ready/result response side.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, UNROLL bits retired per CALC cycle
// Ports: clk, reset (sync, active-high), bus (slave: request in_valid/in_ready/op/a/b, response out_valid/out_ready/result).
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS);
  typedef enum logic [2:0] {IDLE, SETUP, CALC, FIX, DONE} state_t;
  state_t            state, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, p_hi, p_lo, mc, res_q;
  logic [XLEN-1:0]   ma, mb, hi_c, lo_c, quo, rem, fix_res;
  logic [CW-1:0]     cnt;
  logic              neg, sa, sb, a_signed, b_signed, is_div, div0, ovf, ge;
  logic [XLEN:0]     s, r, d;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    a_signed = ~(op_q[0] & (op_q[1] | op_q[2]));
    b_signed = a_signed & (op_q != 3'd2);
    sa       = a_signed & a_q[XLEN-1];
    sb       = b_signed & b_q[XLEN-1];
    ma       = sa ? -a_q : a_q;
    mb       = sb ? -b_q : b_q;
    is_div   = op_q[2];
    div0     = is_div & (b_q == '0);
    ovf      = is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q);
    prod     = neg ? -{p_hi, p_lo} : {p_hi, p_lo};
    quo      = neg ? -p_lo : p_lo;
    rem      = neg ? -p_hi : p_hi;
    fix_res  = (op_q == 3'd0) ? prod[XLEN-1:0] : !is_div ? prod[2*XLEN-1:XLEN] : op_q[1] ? rem : quo;
  end
  // Multiply: {p_hi,p_lo} is the shift-right accumulator with the multiplier in p_lo.
  // Divide: p_hi is the partial remainder, p_lo shifts the dividend out and the quotient in.
  always_comb begin
    hi_c = p_hi;
    lo_c = p_lo;
    s    = '0;
    r    = '0;
    d    = '0;
    ge   = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      s    = {1'b0, hi_c} + {1'b0, mc & {XLEN{lo_c[0]}}};
      r    = {hi_c, lo_c[XLEN-1]};
      d    = r - {1'b0, mc};
      ge   = r >= {1'b0, mc};
      hi_c = is_div ? (ge ? d[XLEN-1:0] : r[XLEN-1:0]) : s[XLEN:1];
      lo_c = is_div ? {lo_c[XLEN-2:0], ge} : {s[0], lo_c[XLEN-1:1]};
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = bus.in_valid ? SETUP : IDLE;
      SETUP:   state_d = (div0 | ovf) ? FIX : CALC;
      CALC:    state_d = (cnt == '0) ? FIX : CALC;
      FIX:     state_d = DONE;
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      mc    <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.in_valid) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      // Special cases preload the final quotient/remainder and clear the sign so FIX passes them through.
      if (state == SETUP) begin
        cnt  <= CW'(STEPS - 1);
        p_hi <= div0 ? a_q : '0;
        p_lo <= div0 ? '1 : ovf ? a_q : is_div ? ma : mb;
        mc   <= is_div ? mb : ma;
        neg  <= ~(div0 | ovf) & ((is_div & op_q[1]) ? sa : sa ^ sb);
      end
      if (state == CALC) begin
        cnt  <= cnt - 1'b1;
        p_hi <= hi_c;
        p_lo <= lo_c;
      end
      if (state == FIX) res_q <= fix_res;
    end
  end
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
endmodule
